// File: rtl/theremin_i2c_init_pkg.sv
// Shared types and constants for the theremin codec initialisation sequencer.
package theremin_i2c_init_pkg;

  // Table geometry: up to 64 entries of 24 bits, entry 0 in the lowest bits.
  localparam int MAX_ENTRIES = 64;
  localparam int ENTRY_BITS  = 24;
  localparam int TABLE_BITS  = MAX_ENTRIES * ENTRY_BITS;

  // Device byte that marks an entry as a pause instead of an I2C transfer.
  localparam logic [7:0] DELAY_MARKER = 8'hFF;

  // Sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_WAIT_IDLE = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT_BUSY = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_CHECK     = 4'd6,
    ST_DELAY     = 4'd7,
    ST_GAP       = 4'd8,
    ST_DONE      = 4'd9,
    ST_FAIL      = 4'd10
  } seq_state_e;

  // One table entry: {device address + R/W bit, register address, data}.
  // For a delay entry the lower 16 bits are the tick count.
  typedef struct packed {
    logic [7:0] dev_op;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } entry_t;

  // Default audio codec bring-up (codec at 7-bit address 0x1A).
  localparam logic [TABLE_BITS-1:0] DEFAULT_INIT_TABLE = {
    {48{24'h000000}},
    24'hFF0005,   // 15: let outputs settle
    24'h340C00,   // 14: power everything up
    24'h350000,   // 13: read back register 0 as a presence check
    24'hFF0001,   // 12: short pause before read-back
    24'h341201,   // 11: activate digital interface
    24'h340679,   // 10: right headphone volume
    24'h340479,   //  9: left headphone volume
    24'h340217,   //  8: right line-in gain
    24'h340017,   //  7: left line-in gain
    24'h340A00,   //  6: digital path, no de-emphasis
    24'h340812,   //  5: analog path, DAC selected
    24'h341000,   //  4: normal mode, 48 kHz
    24'h340E02,   //  3: I2S, 16-bit, slave
    24'h340C10,   //  2: power down outputs during setup
    24'hFF000A,   //  1: 10 ms after reset
    24'h341E00    //  0: codec soft reset
  };

  // True when the entry is a pause rather than a bus transfer.
  function automatic logic is_delay(input entry_t e);
    return e.dev_op == DELAY_MARKER;
  endfunction

  // Pause length in clock cycles; 33 bits holds 16'hFFFF * 100000 without wrap.
  function automatic logic [32:0] delay_cycles(input entry_t e, input int unit_cycles);
    return 33'({e.reg_addr, e.data}) * 33'(unit_cycles);
  endfunction

endpackage

// File: rtl/theremin_i2c_init_rom.sv
// Combinational lookup into the initialisation table; unused slots read as 0.
module theremin_i2c_init_rom
  import theremin_i2c_init_pkg::*;
#(
  parameter int                    ENTRY_COUNT = 16,
  parameter logic [TABLE_BITS-1:0] INIT_TABLE  = DEFAULT_INIT_TABLE
) (
  input  logic [5:0] entry_index,
  output entry_t     entry
);

  entry_t rom_array [MAX_ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_ENTRIES; gi++) begin : g_unpack
      if (gi < ENTRY_COUNT) begin : g_used
        assign rom_array[gi] = INIT_TABLE[gi*ENTRY_BITS +: ENTRY_BITS];
      end else begin : g_unused
        assign rom_array[gi] = '0;
      end
    end
  endgenerate

  assign entry = rom_array[entry_index];

endmodule

// File: rtl/theremin_i2c_init_seq.sv
// Walks the codec init table, issuing I2C commands or pauses, with retries on NACK/timeout.
module theremin_i2c_init_seq
  import theremin_i2c_init_pkg::*;
#(
  parameter int                    ENTRY_COUNT = 16,
  parameter int                    MAX_RETRIES = 3,
  parameter int                    DELAY_UNIT  = 100000,
  parameter int                    ACK_TIMEOUT = 1024,   // must be >= 1
  parameter int                    RETRY_GAP   = 10000,  // must be >= 1
  parameter logic [TABLE_BITS-1:0] INIT_TABLE  = DEFAULT_INIT_TABLE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REINIT,
  output logic [23:0] COMMAND,
  output logic        START,
  input  logic        READY,
  input  logic        ERROR,
  input  logic [7:0]  DATA_OUT,
  output logic [7:0]  LAST_READ,
  output logic [5:0]  STEP,
  output logic        INIT_DONE,
  output logic        INIT_FAIL
);

  localparam logic [3:0] S_IDLE      = ST_IDLE;
  localparam logic [3:0] S_FETCH     = ST_FETCH;
  localparam logic [3:0] S_WAIT_IDLE = ST_WAIT_IDLE;
  localparam logic [3:0] S_ISSUE     = ST_ISSUE;
  localparam logic [3:0] S_WAIT_BUSY = ST_WAIT_BUSY;
  localparam logic [3:0] S_WAIT_DONE = ST_WAIT_DONE;
  localparam logic [3:0] S_CHECK     = ST_CHECK;
  localparam logic [3:0] S_DELAY     = ST_DELAY;
  localparam logic [3:0] S_GAP       = ST_GAP;
  localparam logic [3:0] S_DONE      = ST_DONE;
  localparam logic [3:0] S_FAIL      = ST_FAIL;

  localparam logic [5:0]  LAST_STEP   = 6'(ENTRY_COUNT - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);
  localparam logic [31:0] ACK_LIMIT   = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] GAP_LIMIT   = 32'(RETRY_GAP - 1);

  logic [3:0]  state_reg, state_next;
  logic [5:0]  step_reg, step_next;
  logic [23:0] cmd_reg, cmd_next;
  logic        start_reg, start_next;
  logic [7:0]  last_read_reg, last_read_next;
  logic        done_reg, done_next;
  logic        fail_reg, fail_next;
  logic [7:0]  retry_reg, retry_next;
  logic [31:0] timer_reg, timer_next;     // shared by ACK timeout and retry gap
  logic [32:0] delay_cnt_reg, delay_cnt_next;
  logic        advance;
  logic        attempt_failed;
  entry_t      rom_entry;

  theremin_i2c_init_rom #(
    .ENTRY_COUNT (ENTRY_COUNT),
    .INIT_TABLE  (INIT_TABLE)
  ) u_rom (
    .entry_index (step_reg),
    .entry       (rom_entry)
  );

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    cmd_next       = cmd_reg;
    start_next     = 1'b0;
    last_read_next = last_read_reg;
    done_next      = done_reg;
    fail_next      = fail_reg;
    retry_next     = retry_reg;
    timer_next     = timer_reg;
    delay_cnt_next = delay_cnt_reg;
    advance        = 1'b0;
    attempt_failed = 1'b0;

    case (state_reg)
      S_IDLE: begin
        step_next  = '0;
        retry_next = '0;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        // COMMAND is only ever loaded here; pauses leave it untouched.
        if (is_delay(rom_entry)) begin
          delay_cnt_next = delay_cycles(rom_entry, DELAY_UNIT);
          state_next     = S_DELAY;
        end else begin
          cmd_next   = rom_entry;
          state_next = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (READY) begin
          start_next = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_next = '0;
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!READY) begin
          state_next = S_WAIT_DONE;
        end else if (timer_reg >= ACK_LIMIT) begin
          attempt_failed = 1'b1;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      S_WAIT_DONE: begin
        // The master always completes, so no timeout is needed here.
        if (READY) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!ERROR) begin
          if (cmd_reg[16]) begin
            last_read_next = DATA_OUT;
          end
          advance = 1'b1;
        end else begin
          attempt_failed = 1'b1;
        end
      end
      S_DELAY: begin
        if (delay_cnt_reg == '0) begin
          advance = 1'b1;
        end else begin
          delay_cnt_next = delay_cnt_reg - 33'd1;
        end
      end
      S_GAP: begin
        if (timer_reg >= GAP_LIMIT) begin
          state_next = S_WAIT_IDLE;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      S_DONE, S_FAIL: begin
        if (REINIT) begin
          done_next  = 1'b0;
          fail_next  = 1'b0;
          step_next  = '0;
          retry_next = '0;
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Entry finished: move on, or stop at the last index with STEP held there.
    if (advance) begin
      retry_next = '0;
      if (step_reg == LAST_STEP) begin
        done_next  = 1'b1;
        state_next = S_DONE;
      end else begin
        step_next  = step_reg + 6'd1;
        state_next = S_FETCH;
      end
    end

    // NACK or missing bus activity: back off and retry, or give up on this index.
    if (attempt_failed) begin
      if (retry_reg < RETRY_LIMIT) begin
        retry_next = retry_reg + 8'd1;
        timer_next = '0;
        state_next = S_GAP;
      end else begin
        fail_next  = 1'b1;
        state_next = S_FAIL;
      end
    end
  end

  // State and output registers; reset clears everything, dropping START at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= S_IDLE;
      step_reg      <= '0;
      cmd_reg       <= '0;
      start_reg     <= 1'b0;
      last_read_reg <= '0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      retry_reg     <= '0;
      timer_reg     <= '0;
      delay_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      cmd_reg       <= cmd_next;
      start_reg     <= start_next;
      last_read_reg <= last_read_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
      retry_reg     <= retry_next;
      timer_reg     <= timer_next;
      delay_cnt_reg <= delay_cnt_next;
    end
  end

  assign COMMAND   = cmd_reg;
  assign START     = start_reg;
  assign LAST_READ = last_read_reg;
  assign STEP      = step_reg;
  assign INIT_DONE = done_reg;
  assign INIT_FAIL = fail_reg;

endmodule

// File: tb/tb_theremin_i2c_init_seq.sv
// Directed bench: two sequencers with small tables against a simple I2C master model.
module tb_theremin_i2c_init_seq;

  localparam int DU   = 50;    // delay unit
  localparam int AT   = 16;    // ack timeout
  localparam int RG   = 40;    // retry gap
  localparam int MR   = 3;     // retries
  localparam int XFER = 500;   // master busy time

  localparam logic [64*24-1:0] TABLE_A =
    {{61{24'h000000}}, 24'h1B2F00, 24'hFF0002, 24'h1A0A55};
  localparam logic [64*24-1:0] TABLE_B =
    {{61{24'h000000}}, 24'h1B2F00, 24'h1C1234, 24'h1A0A55};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DUT A signals
  logic        rst_a = 1'b1, reinit_a = 1'b0;
  logic        ready_a = 1'b1, error_a = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic [23:0] cmd_a;
  logic        start_a, done_a, fail_a;
  logic [7:0]  last_a;
  logic [5:0]  step_a;

  // DUT B signals
  logic        rst_b = 1'b1, reinit_b = 1'b0;
  logic        ready_b = 1'b1, error_b = 1'b0;
  logic [7:0]  data_b = 8'h00;
  logic [23:0] cmd_b;
  logic        start_b, done_b, fail_b;
  logic [7:0]  last_b;
  logic [5:0]  step_b;

  theremin_i2c_init_seq #(
    .ENTRY_COUNT(3), .MAX_RETRIES(MR), .DELAY_UNIT(DU),
    .ACK_TIMEOUT(AT), .RETRY_GAP(RG), .INIT_TABLE(TABLE_A)
  ) dut_a (
    .CLK(CLK), .RESET(rst_a), .REINIT(reinit_a), .COMMAND(cmd_a), .START(start_a),
    .READY(ready_a), .ERROR(error_a), .DATA_OUT(data_a), .LAST_READ(last_a),
    .STEP(step_a), .INIT_DONE(done_a), .INIT_FAIL(fail_a)
  );

  theremin_i2c_init_seq #(
    .ENTRY_COUNT(3), .MAX_RETRIES(MR), .DELAY_UNIT(DU),
    .ACK_TIMEOUT(AT), .RETRY_GAP(RG), .INIT_TABLE(TABLE_B)
  ) dut_b (
    .CLK(CLK), .RESET(rst_b), .REINIT(reinit_b), .COMMAND(cmd_b), .START(start_b),
    .READY(ready_b), .ERROR(error_b), .DATA_OUT(data_b), .LAST_READ(last_b),
    .STEP(step_b), .INIT_DONE(done_b), .INIT_FAIL(fail_b)
  );

  // Master model controls for DUT A
  logic        hang_a = 1'b0;
  logic [23:0] nack_cmd_a = 24'h000000;
  int          nack_limit_a = 0;
  int          nack_given_a = 0;
  logic        nack_pend_a = 1'b0;
  int          busy_a = 0;
  logic [7:0]  read_data = 8'h3C;

  // Master model A: READY falls 2 cycles after START, rises 500 cycles later.
  always @(posedge CLK) begin
    if (rst_a) begin
      ready_a <= 1'b1;
      error_a <= 1'b0;
      busy_a  <= 0;
    end else if (busy_a == 0) begin
      if (start_a && !hang_a) begin
        busy_a  <= 1;
        error_a <= 1'b0;
        nack_pend_a <= (cmd_a == nack_cmd_a) && (nack_given_a < nack_limit_a);
        if ((cmd_a == nack_cmd_a) && (nack_given_a < nack_limit_a))
          nack_given_a <= nack_given_a + 1;
      end
    end else begin
      busy_a <= busy_a + 1;
      if (busy_a == 2) ready_a <= 1'b0;
      if (busy_a == XFER + 2) begin
        ready_a <= 1'b1;
        error_a <= nack_pend_a;
        data_a  <= read_data;
        busy_a  <= 0;
      end
    end
  end

  int   busy_b = 0;
  logic nack_pend_b = 1'b0;

  // Master model B: same timing, always NACKs the entry-1 command.
  always @(posedge CLK) begin
    if (rst_b) begin
      ready_b <= 1'b1;
      error_b <= 1'b0;
      busy_b  <= 0;
    end else if (busy_b == 0) begin
      if (start_b) begin
        busy_b      <= 1;
        error_b     <= 1'b0;
        nack_pend_b <= (cmd_b == 24'h1C1234);
      end
    end else begin
      busy_b <= busy_b + 1;
      if (busy_b == 2) ready_b <= 1'b0;
      if (busy_b == XFER + 2) begin
        ready_b <= 1'b1;
        error_b <= nack_pend_b;
        data_b  <= 8'h00;
        busy_b  <= 0;
      end
    end
  end

  int          cyc = 0;
  int          sc_q[$];
  logic [23:0] scmd_q[$];
  int          start_long = 0;
  logic        start_prev = 1'b0;
  int          starts_b = 0, starts_b_e1 = 0;

  // Transaction monitor: log every START with its cycle and command.
  always @(posedge CLK) begin
    cyc        <= cyc + 1;
    start_prev <= start_a;
    if (start_a) begin
      sc_q.push_back(cyc);
      scmd_q.push_back(cmd_a);
      $display("dut_a START  cycle %0d  cmd %06h", cyc, cmd_a);
    end
    if (start_a && start_prev) start_long <= start_long + 1;
    if (start_b) begin
      starts_b <= starts_b + 1;
      if (cmd_b == 24'h1C1234) starts_b_e1 <= starts_b_e1 + 1;
      $display("dut_b START  cycle %0d  cmd %06h", cyc, cmd_b);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int base;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_cmd",   32'(cmd_a),   32'h0);
    check("rst_start", 32'(start_a), 32'h0);
    check("rst_step",  32'(step_a),  32'h0);
    check("rst_last",  32'(last_a),  32'h0);
    check("rst_done",  32'(done_a),  32'h0);
    check("rst_fail",  32'(fail_a),  32'h0);

    // Clean run: write, 2-tick delay, read returning 3C
    base  = sc_q.size();
    rst_a = 1'b0;
    for (int i = 0; i < 5000 && !done_a; i++) @(negedge CLK);
    check("s1_done",   32'(done_a), 32'h1);
    check("s1_fail",   32'(fail_a), 32'h0);
    check("s1_step",   32'(step_a), 32'h2);
    check("s1_last",   32'(last_a), 32'h3C);
    check("s1_cmd",    32'(cmd_a),  32'h1B2F00);
    check("s1_starts", 32'(sc_q.size() - base), 32'd2);
    if (sc_q.size() - base >= 2) begin
      check("s1_cmd0", 32'(scmd_q[base]),     32'h1A0A55);
      check("s1_cmd1", 32'(scmd_q[base + 1]), 32'h1B2F00);
      check("s1_gap",  32'((sc_q[base + 1] - sc_q[base]) >= XFER + 2*DU), 32'd1);
    end

    // Entry 0 NACKed twice then ACKed; read returns A7
    rst_a = 1'b1;
    @(negedge CLK);
    check("s2_rst_last", 32'(last_a), 32'h0);
    check("s2_rst_done", 32'(done_a), 32'h0);
    read_data    = 8'hA7;
    nack_cmd_a   = 24'h1A0A55;
    nack_limit_a = nack_given_a + 2;
    base  = sc_q.size();
    rst_a = 1'b0;
    for (int i = 0; i < 8000 && !done_a; i++) @(negedge CLK);
    check("s2_done",   32'(done_a), 32'h1);
    check("s2_fail",   32'(fail_a), 32'h0);
    check("s2_last",   32'(last_a), 32'hA7);
    check("s2_starts", 32'(sc_q.size() - base), 32'd4);
    if (sc_q.size() - base >= 4) begin
      check("s2_cmd0", 32'(scmd_q[base]),     32'h1A0A55);
      check("s2_cmd1", 32'(scmd_q[base + 1]), 32'h1A0A55);
      check("s2_cmd2", 32'(scmd_q[base + 2]), 32'h1A0A55);
      check("s2_cmd3", 32'(scmd_q[base + 3]), 32'h1B2F00);
      check("s2_gap0", 32'((sc_q[base + 1] - sc_q[base]) >= XFER + RG), 32'd1);
      check("s2_gap1", 32'((sc_q[base + 2] - sc_q[base + 1]) >= XFER + RG), 32'd1);
    end

    // Master never drops READY: four timed-out attempts then FAIL
    rst_a = 1'b1;
    @(negedge CLK);
    hang_a       = 1'b1;
    nack_limit_a = nack_given_a;
    read_data    = 8'h3C;
    base  = sc_q.size();
    rst_a = 1'b0;
    for (int i = 0; i < 3000 && !fail_a; i++) @(negedge CLK);
    check("s3_fail",   32'(fail_a), 32'h1);
    check("s3_done",   32'(done_a), 32'h0);
    check("s3_step",   32'(step_a), 32'h0);
    check("s3_cmd",    32'(cmd_a),  32'h1A0A55);
    check("s3_last",   32'(last_a), 32'h0);
    check("s3_starts", 32'(sc_q.size() - base), 32'd4);
    if (sc_q.size() - base >= 2)
      check("s3_gap", 32'((sc_q[base + 1] - sc_q[base]) >= AT + RG), 32'd1);
    hang_a = 1'b0;

    // Reset while START is high drops it immediately
    rst_a = 1'b1;
    @(negedge CLK);
    rst_a = 1'b0;
    for (int i = 0; i < 100 && !start_a; i++) @(negedge CLK);
    check("s4_start_seen", 32'(start_a), 32'h1);
    rst_a = 1'b1;
    #1;
    check("s4_rst_start", 32'(start_a), 32'h0);
    @(negedge CLK);
    rst_a = 1'b0;

    // REINIT during WAIT_DONE is ignored
    base = sc_q.size();
    for (int i = 0; i < 100 && !start_a; i++) @(negedge CLK);
    repeat (100) @(negedge CLK);
    reinit_a = 1'b1;
    @(negedge CLK);
    reinit_a = 1'b0;
    for (int i = 0; i < 5000 && !done_a; i++) @(negedge CLK);
    check("s4_done",   32'(done_a), 32'h1);
    check("s4_starts", 32'(sc_q.size() - base), 32'd2);

    // REINIT in DONE reruns from entry 0
    reinit_a = 1'b1;
    @(negedge CLK);
    reinit_a = 1'b0;
    check("s4_reinit_done", 32'(done_a), 32'h0);
    check("s4_reinit_step", 32'(step_a), 32'h0);
    for (int i = 0; i < 100 && !start_a; i++) @(negedge CLK);
    check("s4_rerun_cmd", 32'(cmd_a), 32'h1A0A55);
    repeat (540) @(negedge CLK);
    check("s4_delay_step", 32'(step_a), 32'h1);

    // Reset during DELAY clears outputs in the same cycle and restarts
    rst_a = 1'b1;
    #1;
    check("s4_dr_cmd",  32'(cmd_a),  32'h0);
    check("s4_dr_step", 32'(step_a), 32'h0);
    check("s4_dr_last", 32'(last_a), 32'h0);
    check("s4_dr_done", 32'(done_a), 32'h0);
    @(negedge CLK);
    base  = sc_q.size();
    rst_a = 1'b0;
    for (int i = 0; i < 5000 && !done_a; i++) @(negedge CLK);
    check("s4_rs_done",   32'(done_a), 32'h1);
    check("s4_rs_step",   32'(step_a), 32'h2);
    check("s4_rs_last",   32'(last_a), 32'h3C);
    check("s4_rs_starts", 32'(sc_q.size() - base), 32'd2);
    if (sc_q.size() - base >= 1)
      check("s4_rs_cmd0", 32'(scmd_q[base]), 32'h1A0A55);

    // Entry 1 always NACKed: 4 attempts, FAIL with STEP frozen at 1
    rst_b = 1'b0;
    for (int i = 0; i < 6000 && !fail_b; i++) @(negedge CLK);
    check("s5_fail",      32'(fail_b),      32'h1);
    check("s5_done",      32'(done_b),      32'h0);
    check("s5_step",      32'(step_b),      32'h1);
    check("s5_cmd",       32'(cmd_b),       32'h1C1234);
    check("s5_starts_e1", 32'(starts_b_e1), 32'd4);
    check("s5_starts",    32'(starts_b),    32'd5);

    check("start_width", 32'(start_long), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
